tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 SETTLE, default 1, cycles each vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  sweep request; sampled on each rising clk edge.
REQ-005 abcd  output  4  vector driven to both function-under-test instances; abcd[3]=a, abcd[0]=d.
REQ-006 fg  input  1  result from the gate-level function instance.
REQ-007 fa  input  1  result from the assign-level function instance.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high once a sweep has completed; held until the next accepted start or reset.
REQ-010 pass_cnt  output  5  count of vectors that passed, 0..16.
REQ-011 fail_cnt  output  5  count of vectors that failed, 0..16.
REQ-012 first_fail_idx  output  4  abcd value of the first failing vector.
REQ-013 first_fail_vld  output  1  high when first_fail_idx holds a captured value.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE/DONE with start=1 SHALL do all of the following on that edge: go to DRIVE, abcd=0, clear counters and first_fail_vld, busy=1, done=0.
REQ-016 DRIVE SHALL hold abcd stable for exactly SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL evaluate the pass condition for one cycle and increment either pass_cnt or fail_cnt, never both.
REQ-018 The pass condition without oracle SHALL be (fg === fa); X or Z on either input counts as a fail.
REQ-019 SAMPLE with abcd<15 SHALL increment abcd and return to DRIVE; with abcd==15 it SHALL go to DONE, busy=0, done=1, with abcd holding 15.
REQ-020 The first failure in a sweep SHALL latch first_fail_idx=abcd and set first_fail_vld=1; later failures SHALL NOT overwrite it.
REQ-021 done SHALL rise exactly 16*(SETTLE+1) edges after the start-accepting edge; at that point pass_cnt+fail_cnt=16.
REQ-022 start while busy=1 SHALL be ignored with no effect on state, vector or counters.
REQ-023 Counters SHALL NOT wrap; the maximum value 16 is reachable and is never exceeded.

Reset
REQ-024 rst_n=0 at a clk edge SHALL force IDLE, abcd=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, first_fail_idx=0, first_fail_vld=0.
REQ-025 Reset during a sweep SHALL abort it and keep no partial results; a new start is then required.
REQ-026 rst_n SHALL take priority over start on the same edge.

Configuration
REQ-027 Macro TT_SWEEP_ORACLE_EN, when defined, SHALL compile in an internal oracle: f = b&~c | a&~c | c&d, computed on abcd.
REQ-028 With TT_SWEEP_ORACLE_EN defined, the pass condition SHALL be (fg===oracle) && (fa===oracle).
REQ-029 Without TT_SWEEP_ORACLE_EN, the oracle SHALL be absent and the pass condition SHALL be (fg===fa) only; ports are identical in both builds.

Verification
REQ-030 ORACLE_EN, SETTLE=1, fg and fa both correct -> done after 32 edges, pass_cnt=16, fail_cnt=0, first_fail_vld=0.
REQ-031 ORACLE_EN, fg correct, fa tied 0 -> pass_cnt=6, fail_cnt=10, first_fail_idx=3, first_fail_vld=1.
REQ-032 No ORACLE_EN, fg and fa both tied 0 -> pass_cnt=16, fail_cnt=0; done after 32 edges.
REQ-033 SETTLE=3, start pulsed again at edge 10 -> pulse ignored; done after exactly 64 edges.
REQ-034 rst_n low for one edge at edge 20 mid-sweep -> all outputs 0 next cycle; new start -> full correct sweep.
REQ-035 In DONE, start=1 -> counters cleared on that edge, busy=1, done=0, abcd=0.

Source files
------------

// File: rtl/tt_sweep_if.sv
// -----------------------------------------------------------------------------
// tt_sweep_if
// Bundle between the truth-table sweeper and the harness around it: the sweep
// request, the vector sent to both function-under-test instances, their two
// results and the sweep status/result outputs.
//
// Signals:
//   start          sweep request (harness -> sweeper)
//   abcd[3:0]      vector to both instances, abcd[3]=a, abcd[0]=d
//   fg, fa         results of the gate-level / assign-level instances
//   busy, done     sweep in progress / sweep finished (held until restart)
//   pass_cnt[4:0]  vectors that passed, 0..16
//   fail_cnt[4:0]  vectors that failed, 0..16
//   first_fail_idx vector value of the first failure in the sweep
//   first_fail_vld first_fail_idx holds a captured value
//
// Modports: slave = the sweeper, master = whoever drives start/fg/fa.
// -----------------------------------------------------------------------------
interface tt_sweep_if;
    logic       start;
    logic [3:0] abcd;
    logic       fg;
    logic       fa;
    logic       busy;
    logic       done;
    logic [4:0] pass_cnt;
    logic [4:0] fail_cnt;
    logic [3:0] first_fail_idx;
    logic       first_fail_vld;

    modport slave (
        input  start, fg, fa,
        output abcd, busy, done, pass_cnt, fail_cnt, first_fail_idx, first_fail_vld
    );

    modport master (
        output start, fg, fa,
        input  abcd, busy, done, pass_cnt, fail_cnt, first_fail_idx, first_fail_vld
    );
endinterface

// File: rtl/tt_sweep.sv
// -----------------------------------------------------------------------------
// tt_sweep
// Exhaustive truth-table sweeper for a 4-input function. On start it walks
// abcd through 0..15, holds each vector SETTLE cycles, then spends one cycle
// comparing the two implementations' results and counting pass/fail. The
// first failing vector is latched. A full sweep takes 16*(SETTLE+1) cycles.
//
// Parameters:
//   SETTLE  cycles each vector is held before it is sampled (1..15)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset; wins over start
//   io_bus  tt_sweep_if.slave (start, abcd, fg, fa, busy, done, pass_cnt,
//           fail_cnt, first_fail_idx, first_fail_vld)
//
// Build option:
//   TT_SWEEP_ORACLE_EN  when defined, an internal reference
//                       f = b&~c | a&~c | c&d is computed on abcd and both
//                       fg and fa must match it. When undefined, a vector
//                       passes when fg and fa agree. Ports are identical.
// -----------------------------------------------------------------------------
module tt_sweep #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    tt_sweep_if.slave  io_bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [4:0] CNT_MAX     = 5'd16;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_settle_cnt;
    logic [3:0] r_abcd;
    logic [4:0] r_pass_cnt;
    logic [4:0] r_fail_cnt;
    logic [3:0] r_ff_idx;
    logic       r_ff_vld;
    logic       w_pass;
    logic       w_busy;
    logic       w_done;
    logic       w_settled;
    logic       w_last_vec;

    // Counters stop at 16 rather than wrapping into 0.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 5'd1;
    endfunction

    assign w_settled  = (r_settle_cnt == SETTLE_LAST);
    assign w_last_vec = (r_abcd == 4'd15);

`ifdef TT_SWEEP_ORACLE_EN
    logic w_oracle;

    // abcd[3]=a, abcd[2]=b, abcd[1]=c, abcd[0]=d
    assign w_oracle = (r_abcd[2] & ~r_abcd[1]) |
                      (r_abcd[3] & ~r_abcd[1]) |
                      (r_abcd[1] &  r_abcd[0]);
    // Case equality so an X/Z result never counts as a match.
    assign w_pass   = (io_bus.fg === w_oracle) && (io_bus.fa === w_oracle);
`else
    assign w_pass   = (io_bus.fg === io_bus.fa);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE and DONE, so a
    // request during a sweep has no effect.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (io_bus.start) w_state_nxt = DRIVE;
            DRIVE:   if (w_settled)    w_state_nxt = SAMPLE;
            SAMPLE:  w_state_nxt = w_last_vec ? DONE : DRIVE;
            DONE:    if (io_bus.start) w_state_nxt = DRIVE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            DRIVE, SAMPLE: w_busy = 1'b1;
            DONE:          w_done = 1'b1;
            default:       ;
        endcase
    end

    // Vector, settle counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_settle_cnt <= 4'd0;
            r_abcd       <= 4'd0;
            r_pass_cnt   <= 5'd0;
            r_fail_cnt   <= 5'd0;
            r_ff_idx     <= 4'd0;
            r_ff_vld     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (io_bus.start) begin
                        r_settle_cnt <= 4'd0;
                        r_abcd       <= 4'd0;
                        r_pass_cnt   <= 5'd0;
                        r_fail_cnt   <= 5'd0;
                        r_ff_idx     <= 4'd0;
                        r_ff_vld     <= 1'b0;
                    end
                end
                DRIVE: begin
                    // Counter is left at 0 on the way out so the next
                    // vector starts its hold from scratch.
                    r_settle_cnt <= w_settled ? 4'd0 : r_settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    if (w_pass) begin
                        r_pass_cnt <= sat_inc(r_pass_cnt);
                    end else begin
                        r_fail_cnt <= sat_inc(r_fail_cnt);
                        if (!r_ff_vld) begin
                            r_ff_idx <= r_abcd;
                            r_ff_vld <= 1'b1;
                        end
                    end
                    // Vector stays at 15 once the sweep is over.
                    if (!w_last_vec) begin
                        r_abcd <= r_abcd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.abcd           = r_abcd;
    assign io_bus.busy           = w_busy;
    assign io_bus.done           = w_done;
    assign io_bus.pass_cnt       = r_pass_cnt;
    assign io_bus.fail_cnt       = r_fail_cnt;
    assign io_bus.first_fail_idx = r_ff_idx;
    assign io_bus.first_fail_vld = r_ff_vld;

endmodule

// File: tb/tb_tt_sweep.sv
// -----------------------------------------------------------------------------
// tb_tt_sweep
// Directed bench for tt_sweep (SETTLE=3). The harness plays the two function
// instances: per mode it drives fg/fa from abcd as a correct or broken
// implementation of f = b&~c | a&~c | c&d. Expected sweep results are queued
// at each start and popped when done rises. Works with and without
// TT_SWEEP_ORACLE_EN.
// -----------------------------------------------------------------------------
module tb_tt_sweep;

    localparam int S          = 3;
    localparam int DONE_EDGES = 16 * (S + 1);
    localparam int LIMIT      = DONE_EDGES + 20;

    typedef struct {
        int pass_c;
        int fail_c;
        int idx;
        int vld;
    } exp_t;

    logic clk;
    logic rst_n;
    int   mode;
    int   total;
    int   bad;
    exp_t sb_q[$];

    tt_sweep_if bus ();

    tt_sweep #(
        .SETTLE (S)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic f_ref(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3];
        b = v[2];
        c = v[1];
        d = v[0];
        return (b & ~c) | (a & ~c) | (c & d);
    endfunction

    // Modes: 0 both correct, 1 fg correct / fa tied 0, 2 both tied 0,
    //        3 fg wrong at vectors 5 and 9, 4 both inverted (agree, both wrong)
    always_comb begin
        bus.fg = 1'b0;
        bus.fa = 1'b0;
        case (mode)
            0: begin bus.fg = f_ref(bus.abcd);  bus.fa = f_ref(bus.abcd); end
            1: begin bus.fg = f_ref(bus.abcd);  bus.fa = 1'b0;            end
            2: begin bus.fg = 1'b0;             bus.fa = 1'b0;            end
            3: begin
                bus.fg = (bus.abcd == 4'd5 || bus.abcd == 4'd9) ? ~f_ref(bus.abcd)
                                                                 : f_ref(bus.abcd);
                bus.fa = f_ref(bus.abcd);
            end
            4: begin bus.fg = ~f_ref(bus.abcd); bus.fa = ~f_ref(bus.abcd); end
            default: ;
        endcase
    end

    // f is 0 at vectors 0,1,2,6,10,14 (six zeros); first 1 is at vector 3.
    function automatic exp_t exp_for(input int m);
        exp_t e;
        e = '{pass_c: 16, fail_c: 0, idx: 0, vld: 0};
        case (m)
`ifdef TT_SWEEP_ORACLE_EN
            1: e = '{pass_c: 6,  fail_c: 10, idx: 3, vld: 1};
            2: e = '{pass_c: 6,  fail_c: 10, idx: 3, vld: 1};
            3: e = '{pass_c: 14, fail_c: 2,  idx: 5, vld: 1};
            4: e = '{pass_c: 0,  fail_c: 16, idx: 0, vld: 1};
`else
            1: e = '{pass_c: 6,  fail_c: 10, idx: 3, vld: 1};
            2: e = '{pass_c: 16, fail_c: 0,  idx: 0, vld: 0};
            3: e = '{pass_c: 14, fail_c: 2,  idx: 5, vld: 1};
            4: e = '{pass_c: 16, fail_c: 0,  idx: 0, vld: 0};
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_abcd"}, 32'(bus.abcd),           0);
        check({tag, "_busy"}, 32'(bus.busy),           0);
        check({tag, "_done"}, 32'(bus.done),           0);
        check({tag, "_pass"}, 32'(bus.pass_cnt),       0);
        check({tag, "_fail"}, 32'(bus.fail_cnt),       0);
        check({tag, "_idx"},  32'(bus.first_fail_idx), 0);
        check({tag, "_vld"},  32'(bus.first_fail_vld), 0);
    endtask

    // restart_at / reset_at: edge number (after the start edge) at which a
    // second start pulse / a one-edge reset is applied; 0 = none.
    task automatic run_sweep(input int m, input int restart_at, input int reset_at);
        int   n;
        int   exp_a;
        exp_t e;
        mode = m;
        sb_q.push_back(exp_for(m));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy", 32'(bus.busy),           1);
        check("start_done", 32'(bus.done),           0);
        check("start_abcd", 32'(bus.abcd),           0);
        check("start_pass", 32'(bus.pass_cnt),       0);
        check("start_fail", 32'(bus.fail_cnt),       0);
        check("start_vld",  32'(bus.first_fail_vld), 0);
        n = 0;
        while (!bus.done && n < LIMIT) begin
            bus.start = (n + 1 == restart_at);
            if (n + 1 == reset_at) rst_n = 1'b0;
            tick();
            n++;
            bus.start = 1'b0;
            if (reset_at != 0 && n == reset_at) begin
                rst_n = 1'b1;
                check_all_zero("abort");
                void'(sb_q.pop_back());
                return;
            end
            exp_a = n / (S + 1);
            if (exp_a > 15) exp_a = 15;
            check("abcd_seq", 32'(bus.abcd), exp_a);
            check("busy_seq", 32'(bus.busy), (n < DONE_EDGES) ? 1 : 0);
        end
        check("done_edges", n, DONE_EDGES);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'(sb_q.size()), 1);
        end else begin
            e = sb_q.pop_front();
            check("pass_cnt", 32'(bus.pass_cnt),       e.pass_c);
            check("fail_cnt", 32'(bus.fail_cnt),       e.fail_c);
            check("ff_idx",   32'(bus.first_fail_idx), e.idx);
            check("ff_vld",   32'(bus.first_fail_vld), e.vld);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        mode      = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_all_zero("reset");

        // Idle with no start stays idle
        tick();
        tick();
        check("idle_busy", 32'(bus.busy), 0);

        run_sweep(0, 0, 0);

        // done and results hold while start is low
        tick();
        tick();
        tick();
        check("hold_done", 32'(bus.done),     1);
        check("hold_pass", 32'(bus.pass_cnt), exp_for(0).pass_c);
        check("hold_abcd", 32'(bus.abcd),     15);

        run_sweep(1, 0, 0);       // restart straight from DONE
        run_sweep(2, 0, 0);
        run_sweep(3, 0, 0);
        run_sweep(4, 0, 0);
        run_sweep(1, 10, 0);      // second start mid-sweep is ignored
        run_sweep(1, 0, 20);      // reset aborts the sweep
        check("abort_idle", 32'(bus.busy), 0);
        run_sweep(3, 0, 0);

        // Reset beats start on the same edge (from DONE)
        rst_n     = 1'b0;
        bus.start = 1'b1;
        tick();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        check_all_zero("rst_prio");
        tick();
        check("rst_prio_busy", 32'(bus.busy), 0);

        run_sweep(0, 0, 0);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
